// File: rtl/vec_alu_pkg.sv
// Shared opcodes, FSM state encoding and operand-select helper for the vector ALU.
package vec_alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_OR    = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
   localparam logic [OP_W-1:0] OP_XOR_S = 4'b0101;
   localparam logic [OP_W-1:0] OP_SHL_S = 4'b0110;
   localparam logic [OP_W-1:0] OP_SHR_S = 4'b0111;
   localparam logic [OP_W-1:0] OP_ROL_S = 4'b1000;
   localparam logic [OP_W-1:0] OP_ROR_S = 4'b1001;
   localparam logic [OP_W-1:0] OP_ADD_S = 4'b1010;
   localparam logic [OP_W-1:0] OP_SUB_S = 4'b1011;
   localparam logic [OP_W-1:0] OP_VFS   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // True for opcodes whose second operand is the broadcast scalar.
   function automatic logic is_escalar(input logic [OP_W-1:0] op);
      case (op)
         OP_XOR_S, OP_SHL_S, OP_SHR_S, OP_ROL_S,
         OP_ROR_S, OP_ADD_S, OP_SUB_S: is_escalar = 1'b1;
         default:                      is_escalar = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_lane.sv
// Single-element combinational ALU; b is either the lane operand or the broadcast scalar.
module alu_lane
   import vec_alu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [OP_W-1:0]   opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   localparam int unsigned       ROT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DATA_W-1:0] W_VAL = DATA_W'(DATA_W);

   logic             amt_big;
   logic [ROT_W-1:0] rot_amt;

   // Opcode decode; unknown opcodes produce zero.
   always_comb begin
      y       = '0;
      amt_big = (b >= W_VAL);
      rot_amt = ROT_W'(b % W_VAL);
      case (opcode)
         OP_OR:            y = a | b;
         OP_ADD, OP_VFS:   y = a + b;
         OP_SUB:           y = a - b;
         OP_XOR_S:         y = a ^ b;
         OP_SHL_S:         y = amt_big ? '0 : (a << b);
         OP_SHR_S:         y = amt_big ? '0 : (a >> b);
         OP_ROL_S:         y = DATA_W'(({a, a} << rot_amt) >> DATA_W);
         OP_ROR_S:         y = DATA_W'({a, a} >> rot_amt);
         OP_ADD_S:         y = a + b;
         OP_SUB_S:         y = a - b;
         default:          y = '0;
      endcase
   end

endmodule

// File: rtl/vec_alu_lanes.sv
// Multi-lane vector ALU: one command streams ceil(vlen/LANES) masked result beats.
module vec_alu_lanes
   import vec_alu_pkg::*;
#(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned LANES    = 4,
   parameter  int unsigned MAX_VLEN = 64,
   localparam int unsigned VLEN_W   = $clog2(MAX_VLEN + 1),
   localparam int unsigned BEAT_W   = $clog2(MAX_VLEN / LANES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OP_W-1:0]         cmd_opcode,
   input  logic [VLEN_W-1:0]       cmd_vlen,
   input  logic [DATA_W-1:0]       cmd_escalar,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] val_a,
   input  logic [LANES*DATA_W-1:0] val_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] resultado,
   output logic [LANES-1:0]        out_mask,
   output logic                    out_last,
   output logic                    busy
);

   localparam int unsigned IDX_W = VLEN_W + BEAT_W;

   state_t                  state, state_nx;
   logic [OP_W-1:0]         op_q;
   logic [DATA_W-1:0]       esc_q;
   logic [VLEN_W-1:0]       vlen_q;
   logic [BEAT_W-1:0]       beats_rem;
   logic [BEAT_W-1:0]       beat_idx;
   logic [VLEN_W-1:0]       vlen_eff_c;
   logic [BEAT_W-1:0]       beats_c;
   logic                    cmd_fire;
   logic                    beat_fire;
   logic [LANES-1:0]        live;
   logic [LANES*DATA_W-1:0] res_c;
   logic [DATA_W-1:0]       lane_y [LANES];

   // Clamp requested length and derive the beat count of the offered command.
   always_comb begin
      vlen_eff_c = (cmd_vlen > VLEN_W'(MAX_VLEN)) ? VLEN_W'(MAX_VLEN) : cmd_vlen;
      beats_c    = BEAT_W'((IDX_W'(vlen_eff_c) + IDX_W'(LANES - 1)) / IDX_W'(LANES));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake readies.
   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && (beats_c != '0)) state_nx = ST_RUN;
         end
         ST_RUN: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && (beats_rem == BEAT_W'(1))) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_valid && out_ready && out_last) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign beat_fire = in_valid && in_ready;
   assign busy      = (state != ST_IDLE) || out_valid;

   // Latched command and beat counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         esc_q     <= '0;
         vlen_q    <= '0;
         beats_rem <= '0;
         beat_idx  <= '0;
      end else if (cmd_fire) begin
         op_q      <= cmd_opcode;
         esc_q     <= cmd_escalar;
         vlen_q    <= vlen_eff_c;
         beats_rem <= beats_c;
         beat_idx  <= '0;
      end else if (beat_fire) begin
         beats_rem <= beats_rem - BEAT_W'(1);
         beat_idx  <= beat_idx + BEAT_W'(1);
      end
   end

   // Per-lane ALUs with scalar broadcast on the second operand.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [DATA_W-1:0] opb;
      assign opb = is_escalar(op_q) ? esc_q : val_b[g*DATA_W +: DATA_W];
      alu_lane #(.DATA_W(DATA_W)) u_lane (
         .opcode (op_q),
         .a      (val_a[g*DATA_W +: DATA_W]),
         .b      (opb),
         .y      (lane_y[g])
      );
   end

   // Tail mask: lane is live while its element index is below the vector length.
   always_comb begin
      live  = '0;
      res_c = '0;
      for (int i = 0; i < LANES; i++) begin
         live[i] = (IDX_W'(beat_idx) * IDX_W'(LANES) + IDX_W'(i)) < IDX_W'(vlen_q);
         res_c[i*DATA_W +: DATA_W] = live[i] ? lane_y[i] : '0;
      end
   end

   // Result stage: load on accepted beat, hold under backpressure, retire on out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         resultado <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
      end else if (beat_fire) begin
         out_valid <= 1'b1;
         resultado <= res_c;
         out_mask  <= live;
         out_last  <= (beats_rem == BEAT_W'(1));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/vec_alu_lanes.md
Name: vec_alu_lanes

Overview:
Parametrised multi-lane vector ALU, successor to the single-element 8-bit ALU in procesador_vectorial.
- Accepts one vector command (opcode, vector length, scalar operand).
- Streams element groups of LANES elements per beat through a registered result stage with valid/ready flow control.
- Handles tail masking, scalar broadcast and backpressure.
- Sits between the vector register file read ports and the write-back path.

Parameters:
DATA_W, 8, element width in bits
LANES, 4, elements processed per beat
MAX_VLEN, 64, maximum vector length in elements
VLEN_W, $clog2(MAX_VLEN+1), localparam, width of vector length fields
BEAT_W, $clog2(MAX_VLEN/LANES+1), localparam, width of beat counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_opcode  in  4  operation code (encoding below)
cmd_vlen  in  VLEN_W  vector length in elements
cmd_escalar  in  DATA_W  scalar operand for vector-scalar opcodes
in_valid  in  1  operand beat offered
in_ready  out  1  operand beat accepted when high with in_valid
val_a  in  LANES*DATA_W  operand A, lane i at bits [i*DATA_W +: DATA_W]
val_b  in  LANES*DATA_W  operand B (ignored for vector-scalar opcodes)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
resultado  out  LANES*DATA_W  result beat
out_mask  out  LANES  lane i holds a live element
out_last  out  1  final beat of the command
busy  out  1  command in progress or result pending

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - out_valid=0, out_last=0, out_mask=0, resultado=0, busy=0, cmd_ready=1, in_ready=0.
  - Counters and latched command are cleared.
  - Reset mid-command discards the command and any pending result without emitting further beats.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid, latch opcode/escalar and vlen_eff=min(cmd_vlen,MAX_VLEN). Compute beats=ceil(vlen_eff/LANES).
    - beats=0: stay in IDLE, no output.
    - beats>0: go to RUN.
  - RUN: cmd_ready=0, in_ready=(!out_valid || out_ready). Each accepted beat decrements the remaining count. After the last beat is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Go to IDLE in the cycle out_valid&&out_ready retires the beat with out_last=1. A new command is accepted only in IDLE (no overlap).
- Latency: one cycle from operand acceptance to out_valid. The output register holds its value while out_valid && !out_ready. Throughput is one beat per cycle under no backpressure.
- busy = (state!=IDLE) || out_valid.
- Opcodes, per lane; "s" denotes the latched cmd_escalar broadcast to all lanes:
  - 0000 a|b
  - 0001 a+b
  - 0010 a-b
  - 0101 a^s
  - 0110 a<<s
  - 0111 a>>s
  - 1000 rotl(a, s mod DATA_W)
  - 1001 rotr(a, s mod DATA_W)
  - 1010 a+s
  - 1011 a-s
  - 1111 a+b (VFS offset)
  - Any other opcode gives result 0. No latches are allowed.
- Width and arithmetic rules:
  - Add/sub wrap modulo 2^DATA_W, with no carry or borrow out.
  - Logical shifts with amount >= DATA_W give 0.
  - A rotate by 0 returns a.
- Tail masking: for beat k, lane i is live iff k*LANES+i < vlen_eff. Dead lanes output resultado lane = 0 and out_mask bit = 0. Every full beat has out_mask all-ones.
- out_last=1 only on the beat with k = beats-1.
- Simultaneous events:
  - out_ready and a new in_valid in the same cycle: the old result retires and the new result loads; no bubble.
  - cmd_valid outside IDLE is ignored (cmd_ready=0).

Decomposition:
- Shared package vec_alu_pkg holds:
  - opcode localparams: OP_OR, OP_ADD, OP_SUB, OP_XOR_S, OP_SHL_S, OP_SHR_S, OP_ROL_S, OP_ROR_S, OP_ADD_S, OP_SUB_S, OP_VFS
  - FSM state encoding: ST_IDLE, ST_RUN, ST_DRAIN
  - helper function is_escalar(opcode)
- Sub-module alu_lane: combinational, one element with parameter DATA_W. Instantiate LANES times via generate. The top holds the FSM, counters, mask generation and output register.

Test Plan:
- Reset: assert rst for 2 cycles mid-RUN with out_ready=0 -> out_valid=0, busy=0, cmd_ready=1 next cycle; no further beats emitted.
- Full vectors: OP_ADD, vlen=8, LANES=4, a lanes={1,2,3,255}, b lanes={1,1,1,1} -> 2 beats, first resultado={2,3,4,0}, out_mask=1111, out_last on beat 2 only.
- Tail: OP_SUB_S, vlen=5, escalar=3, a lanes={10,2,7,9} then {4,...} -> beat 1 {7,255,4,6} mask 1111; beat 2 {1,0,0,0} mask 0001, out_last=1.
- Rotate/shift boundaries: OP_ROL_S escalar=9 with a=8'h81 -> 8'h03. OP_SHL_S escalar=8 -> 0. OP_ROR_S escalar=0 -> a unchanged.
- Backpressure: vlen=12, out_ready toggled 1010... -> no beat lost or duplicated, in_ready low whenever out_valid&&!out_ready, 3 beats in order.
- Edges: vlen=0 -> no output, cmd_ready high again next cycle. vlen=100 -> clamped to 64, 16 beats. Opcode 0011 -> all live lanes 0. cmd_valid during RUN -> ignored.
